// File: rtl/free_list_if.sv
// free_list_if: rename-side alloc/free/checkpoint/recover bundle for the physical-register free list
interface free_list_if #(
  parameter int N_ARCH_REGS = 32,
  parameter int N_PHYS_REGS = 64,
  parameter int ROB_DEPTH   = 32
);
  localparam int PHYS_W = $clog2(N_PHYS_REGS);
  localparam int CNT_W  = $clog2(N_PHYS_REGS - N_ARCH_REGS) + 1;
  localparam int ROB_W  = $clog2(ROB_DEPTH);
  logic              alloc_req_i;
  logic              alloc_valid_o;
  logic [PHYS_W-1:0] alloc_phys_o;
  logic              free_i;
  logic [PHYS_W-1:0] free_phys_i;
  logic              checkpoint_take;
  logic [ROB_W-1:0]  checkpoint_tag;
  logic              recover_i;
  logic [ROB_W-1:0]  recover_tag_i;
  logic [CNT_W-1:0]  free_count_o;
  modport master (
    output alloc_req_i, free_i, free_phys_i, checkpoint_take, checkpoint_tag, recover_i, recover_tag_i,
    input  alloc_valid_o, alloc_phys_o, free_count_o
  );
  modport slave (
    input  alloc_req_i, free_i, free_phys_i, checkpoint_take, checkpoint_tag, recover_i, recover_tag_i,
    output alloc_valid_o, alloc_phys_o, free_count_o
  );
endinterface

// File: rtl/free_list.sv
// free_list: circular FIFO of free physical registers with per-ROB-tag read-pointer checkpoints
module free_list #(
  parameter int N_ARCH_REGS = 32,
  parameter int N_PHYS_REGS = 64,
  parameter int ROB_DEPTH   = 32
) (
  input logic        clk,
  input logic        rst_n,
  free_list_if.slave fl
);
  localparam int FL_DEPTH = N_PHYS_REGS - N_ARCH_REGS;
  localparam int IDX_W    = $clog2(FL_DEPTH);
  localparam int PTR_W    = IDX_W + 1;
  localparam int PHYS_W   = $clog2(N_PHYS_REGS);
  logic [PHYS_W-1:0] entry_q [FL_DEPTH];
  logic [PTR_W-1:0]  slot_q [ROB_DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d, head_next, count;
  logic              do_alloc, do_free;
  // Occupancy, grant/free qualification and next pointers; recovery overrides the allocation
  always_comb begin
    count     = tail_q - head_q;
    do_alloc  = fl.alloc_req_i && count != '0;
    do_free   = fl.free_i && fl.free_phys_i != '0 && count != PTR_W'(FL_DEPTH);
    head_next = head_q + PTR_W'(do_alloc);
    head_d    = fl.recover_i ? slot_q[fl.recover_tag_i] : head_next;
    tail_d    = tail_q + PTR_W'(do_free);
  end
  assign fl.free_count_o  = count;
  assign fl.alloc_valid_o = count != '0;
  assign fl.alloc_phys_o  = entry_q[head_q[IDX_W-1:0]];
  // Pointers, list storage and checkpoint slots; tail is never restored so a commit during recovery still lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= PTR_W'(FL_DEPTH);
      for (int i = 0; i < FL_DEPTH; i++) entry_q[i] <= PHYS_W'(N_ARCH_REGS + i);
      for (int i = 0; i < ROB_DEPTH; i++) slot_q[i] <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      if (do_free) entry_q[tail_q[IDX_W-1:0]] <= fl.free_phys_i;
      if (fl.checkpoint_take && !fl.recover_i) slot_q[fl.checkpoint_tag] <= head_next;
    end
  end
endmodule

// File: doc/free_list.md
# free_list

Physical-register free list for the rename stage, counterpart to the RAT: it supplies the new physical destination tag written into the map table on every renamed instruction and takes back the previous mapping of each committed destination. Allocation is a circular FIFO of free physical register numbers. Per-ROB-tag checkpoints of the read pointer let a branch recovery return every register allocated after the mispredicted branch in one cycle, in lockstep with the RAT restore.

## Interface
- N_ARCH_REGS, default ooop_types::N_ARCH_REGS: architectural registers; physical regs 0..N_ARCH_REGS-1 are mapped at reset.
- N_PHYS_REGS, default ooop_types::N_PHYS_REGS: physical registers. N_PHYS_REGS-N_ARCH_REGS (FL_DEPTH) must be a power of two.
- ROB_DEPTH, default ooop_types::ROB_DEPTH: number of checkpoint slots, indexed by ROB tag.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- alloc_req_i  in  1  rename requests one register this cycle.
- alloc_valid_o  out  1  list non-empty; alloc_phys_o is valid.
- alloc_phys_o  out  $clog2(N_PHYS_REGS)  register granted when alloc_req_i && alloc_valid_o.
- free_i  in  1  commit returns a register.
- free_phys_i  in  $clog2(N_PHYS_REGS)  register being returned (old mapping of committed rd).
- checkpoint_take  in  1  snapshot read pointer into slot checkpoint_tag.
- checkpoint_tag  in  ooop_types::ROB_W  checkpoint slot.
- recover_i  in  1  restore read pointer from slot recover_tag_i.
- recover_tag_i  in  ooop_types::ROB_W  slot to restore.
- free_count_o  out  $clog2(FL_DEPTH)+1  number of free entries.

## Operation
- Storage: FL_DEPTH entries of $clog2(N_PHYS_REGS) bits; head and tail pointers are $clog2(FL_DEPTH)+1 bits (wrap bit on MSB).
- Reset (async, rst_n low): entry i = N_ARCH_REGS+i; head = 0; tail = FL_DEPTH (wrap bit set, index 0); every checkpoint slot = 0. Outputs: alloc_valid_o=1, alloc_phys_o=N_ARCH_REGS, free_count_o=FL_DEPTH.
- free_count_o = tail - head (modulo 2^width); alloc_valid_o = (free_count_o != 0); alloc_phys_o = entry[head index].
- Allocate: alloc_req_i && alloc_valid_o -> head+1. A request while empty is ignored; head does not move.
- Free: free_i && free_phys_i != 0 && free_count_o != FL_DEPTH -> entry[tail index] = free_phys_i, tail+1. Register 0 is never freed (x0 stays pinned to p0). A free while full is dropped; it is a protocol error and the bench asserts it never occurs.
- head_next = head after this cycle's allocation.
- Checkpoint: checkpoint_take -> slot[checkpoint_tag] = head_next, so the snapshot includes the allocation made by the checkpointing instruction itself.
- Recover, which has priority: head = slot[recover_tag_i]. Allocation and checkpoint_take in the same cycle are ignored. A free in the same cycle is still applied, because older instructions may commit during recovery. Tail is never restored.
- Invariant: free entries plus uncommitted allocations = FL_DEPTH, so tail never overwrites entries between a live checkpoint head and the current head. Recovery therefore needs no data copy.
- Allocate and free in the same cycle: both apply and the count is unchanged. When empty, a freed register is not bypassed to alloc_phys_o; it becomes allocatable the next cycle.

## Timing
- alloc_phys_o and alloc_valid_o are combinational from registered state: the grant is in the same cycle and head advances at the edge.
- Free, checkpoint and recover take effect at the rising edge. Values are visible on outputs the following cycle.
- Recovery latency is 1 cycle. alloc_phys_o in the cycle after recover_i equals the first register allocated after the checkpoint.
- Reset assertion takes effect immediately, mid-operation included. Deassertion is synchronized externally; the first edge after deassert is a normal cycle.

## Test plan
- Reset, N_ARCH_REGS=32, N_PHYS_REGS=64 -> alloc_phys_o=32, free_count_o=32, alloc_valid_o=1. Allocate 32 times -> grants 32..63, then alloc_valid_o=0 and free_count_o=0.
- Empty list, alloc_req_i=1 and free_i=1 with free_phys_i=5 -> no grant, count becomes 1. Next cycle alloc_phys_o=5.
- Allocate 3 (32,33,34) with checkpoint_take on the second, tag 7 -> slot 7 holds head=2. Allocate 35,36, then recover_i with tag 7 -> next alloc_phys_o=34, free_count_o=30.
- Recover in the same cycle as free_i=1, free_phys_i=9 and alloc_req_i=1 -> head restored, no allocation, tail advances, count includes 9.
- free_i with free_phys_i=0 -> no change to tail or count. Alloc and free together at count 10 -> count stays 10.
- Assert rst_n low asynchronously mid-burst, between edges -> outputs return to reset values immediately. Refill and wrap around twice with alternating alloc/free -> grant order matches free order.
